// File: rtl/kernel_loader.sv
// Packs UNITS stream words into one kernel vector and strobes it into the kernel buffer.
// Commit waits for commit_ready, so the buffer never latches a partial set.
module kernel_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int UNITS      = 10,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       s_data,
   input  logic                        s_valid,
   input  logic                        s_last,
   output logic                        s_ready,
   input  logic                        flush,
   input  logic                        commit_ready,
   output logic [DATA_WIDTH*UNITS-1:0] x_out,
   output logic                        buff_en,
   output logic                        err_len,
   output logic [CNT_WIDTH-1:0]        sets_loaded
);

   localparam int CW = (UNITS > 1) ? $clog2(UNITS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(UNITS - 1);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      FULL   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [DATA_WIDTH*UNITS-1:0]   x_out_q, x_out_d;
   logic                          err_q, err_d;
   logic [CNT_WIDTH-1:0]          sets_q, sets_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_out_d = x_out_q;
      err_d   = err_q;
      sets_d  = sets_q;
      case (state_q)
         FILL: begin
            // flush takes priority over a word presented in the same cycle
            if (flush) begin
               cnt_d = '0;
            end else if (s_valid) begin
               for (int i = 0; i < UNITS; i++) begin
                  if (cnt_q == CW'(i)) begin
                     x_out_d[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
                  end
               end
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = FULL;
                  if (!s_last) begin
                     err_d = 1'b1;
                  end
               end else if (s_last) begin
                  cnt_d = '0;
                  err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         FULL: begin
            if (commit_ready) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            sets_d  = sets_q + 1'b1;
            state_d = FILL;
         end
         default: begin
            state_d = FILL;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         x_out_q <= '0;
         err_q   <= 1'b0;
         sets_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_out_q <= x_out_d;
         err_q   <= err_d;
         sets_q  <= sets_d;
      end
   end

   // Handshake outputs decode the state register only; rst masks s_ready while asserted.
   assign s_ready     = (state_q == FILL) && !rst;
   assign buff_en     = (state_q == COMMIT);
   assign x_out       = x_out_q;
   assign err_len     = err_q;
   assign sets_loaded = sets_q;

endmodule
